pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage. It holds the current fetch address and selects the next one by priority: trap vector, then execute-stage redirect, then a predicted call/return target, then sequential increment. A circular return-address stack (RAS) supplies targets for predicted returns. It sits between the branch/trap logic and instruction memory, and handles stalls, flushes and call/return prediction.

---
 rtl/pc_gen.sv | 109 ++++++++++
 tb/tb_pc_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator with a circular return-address stack.
// The next PC is chosen by priority: trap, then redirect, then stall, then call,
// then return, then sequential increment.
// Ports:
//   clk, rst (async, active-low)
//   en                        fetch advance (0 = stall)
//   trap_valid/trap_vec       trap load, highest priority
//   redirect_valid/redirect_pc execute-stage correction
//   call/call_target          predecoded call: push pc+INC, jump to target
//   ret                       predecoded return: pop RAS into pc
//   pc                        current fetch address
//   ras_count/ras_top         RAS occupancy and top entry (0 when empty)
//   ras_miss                  one-cycle pulse after a return taken with the RAS empty
module pc_gen #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = 'h00400000,
   parameter int unsigned     INC       = 4,
   parameter int unsigned     RAS_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic                           trap_valid,
   input  logic [XLEN-1:0]                trap_vec,
   input  logic                           redirect_valid,
   input  logic [XLEN-1:0]                redirect_pc,
   input  logic                           call,
   input  logic [XLEN-1:0]                call_target,
   input  logic                           ret,
   output logic [XLEN-1:0]                pc,
   output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
   output logic [XLEN-1:0]                ras_top,
   output logic                           ras_miss
);

   localparam int unsigned PW = $clog2(RAS_DEPTH);
   localparam int unsigned CW = $clog2(RAS_DEPTH+1);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            miss_q, miss_d;
   logic            push;
   logic [XLEN-1:0] ras_q [RAS_DEPTH];
   logic [XLEN-1:0] pc_inc;
   logic [PW-1:0]   top_idx;

   assign pc_inc  = pc_q + XLEN'(INC);
   assign top_idx = ptr_q - PW'(1);

   // Top entry sits one below the write pointer; an emptied stack reads as 0.
   assign ras_top   = (cnt_q != '0) ? ras_q[top_idx] : '0;
   assign pc        = pc_q;
   assign ras_count = cnt_q;
   assign ras_miss  = miss_q;

   // Next-PC selection and RAS bookkeeping
   always_comb begin
      pc_d   = pc_q;
      ptr_d  = ptr_q;
      cnt_d  = cnt_q;
      miss_d = 1'b0;
      push   = 1'b0;
      if (trap_valid) begin
         // Pointer is left alone; clearing the count is enough to empty the stack.
         pc_d  = trap_vec;
         cnt_d = '0;
      end else if (redirect_valid) begin
         pc_d = redirect_pc;
      end else if (en) begin
         if (call) begin
            push  = 1'b1;
            pc_d  = call_target;
            ptr_d = ptr_q + PW'(1);
            // Saturated count means the push overwrote the oldest entry.
            cnt_d = (cnt_q == CW'(RAS_DEPTH)) ? cnt_q : cnt_q + CW'(1);
         end else if (ret) begin
            if (cnt_q != '0) begin
               pc_d  = ras_top;
               ptr_d = top_idx;
               cnt_d = cnt_q - CW'(1);
            end else begin
               pc_d   = pc_inc;
               miss_d = 1'b1;
            end
         end else begin
            pc_d = pc_inc;
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q   <= RESET_VEC;
         ptr_q  <= '0;
         cnt_q  <= '0;
         miss_q <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      end else begin
         pc_q   <= pc_d;
         ptr_q  <= ptr_d;
         cnt_q  <= cnt_d;
         miss_q <= miss_d;
         if (push) ras_q[ptr_q] <= pc_inc;
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: directed vector table, hand sequences for RAS overflow
// and asynchronous reset, then random traffic against a queue-based model.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        en, trap_valid, redirect_valid, call, ret;
   logic [31:0] trap_vec, redirect_pc, call_target;
   logic [31:0] pc, ras_top;
   logic [2:0]  ras_count;
   logic        ras_miss;

   pc_gen dut (
      .clk(clk), .rst(rst), .en(en),
      .trap_valid(trap_valid), .trap_vec(trap_vec),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .call(call), .call_target(call_target), .ret(ret),
      .pc(pc), .ras_count(ras_count), .ras_top(ras_top), .ras_miss(ras_miss)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en, trap, redir, call, ret;
      logic [31:0] tv, rp, ct;
      logic [31:0] e_pc;
      int          e_cnt;
      logic [31:0] e_top;
      logic        e_miss;
   } vec_t;

   int total = 0;
   int bad   = 0;

   // Reference model: return addresses kept as a bounded queue, newest at the back.
   logic [31:0] m_pc;
   logic [31:0] m_ras [$];
   logic        m_miss;

   function automatic vec_t mk(input logic e, t, r, c, rt,
                               input logic [31:0] tv, rp, ct,
                               input logic [31:0] epc, input int ecnt,
                               input logic [31:0] etop, input logic emiss);
      vec_t v;
      v.en = e; v.trap = t; v.redir = r; v.call = c; v.ret = rt;
      v.tv = tv; v.rp = rp; v.ct = ct;
      v.e_pc = epc; v.e_cnt = ecnt; v.e_top = etop; v.e_miss = emiss;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h00400000;
      m_ras.delete();
      m_miss = 1'b0;
   endtask

   task automatic model_step(input vec_t v);
      m_miss = 1'b0;
      if (v.trap) begin
         m_pc = v.tv;
         m_ras.delete();
      end else if (v.redir) begin
         m_pc = v.rp;
      end else if (v.en) begin
         if (v.call) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
            m_pc = v.ct;
         end else if (v.ret) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin
               m_pc = m_pc + 32'd4;
               m_miss = 1'b1;
            end
         end else begin
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   function automatic logic [31:0] m_top();
      return (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
   endfunction

   // Drive one cycle of inputs, clock it, and advance the model.
   task automatic apply(input vec_t v);
      en = v.en; trap_valid = v.trap; redirect_valid = v.redir;
      call = v.call; ret = v.ret;
      trap_vec = v.tv; redirect_pc = v.rp; call_target = v.ct;
      @(posedge clk);
      model_step(v);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".pc"},   pc, m_pc);
      chk({tag, ".cnt"},  32'(ras_count), 32'(m_ras.size()));
      chk({tag, ".top"},  ras_top, m_top());
      chk({tag, ".miss"}, 32'(ras_miss), 32'(m_miss));
   endtask

   vec_t vecs [$];
   vec_t v;

   initial begin
      // Directed table: inputs for one edge and the state expected after it.
      vecs.push_back(mk(1,0,0,0,0, 0,0,0, 32'h00400004,0,0,0));
      vecs.push_back(mk(1,0,0,0,0, 0,0,0, 32'h00400008,0,0,0));
      vecs.push_back(mk(1,0,0,0,0, 0,0,0, 32'h0040000C,0,0,0));
      vecs.push_back(mk(0,0,0,0,0, 0,0,0, 32'h0040000C,0,0,0));
      vecs.push_back(mk(0,0,0,1,1, 0,0,32'h00700000, 32'h0040000C,0,0,0));
      vecs.push_back(mk(0,0,1,0,0, 0,32'h00401000,0, 32'h00401000,0,0,0));
      vecs.push_back(mk(1,0,1,0,0, 0,32'h00400010,0, 32'h00400010,0,0,0));
      vecs.push_back(mk(1,0,0,1,0, 0,0,32'h00402000, 32'h00402000,1,32'h00400014,0));
      vecs.push_back(mk(1,0,0,0,1, 0,0,0, 32'h00400014,0,0,0));
      vecs.push_back(mk(1,0,0,0,1, 0,0,0, 32'h00400018,0,0,1));
      vecs.push_back(mk(1,0,0,0,0, 0,0,0, 32'h0040001C,0,0,0));
      vecs.push_back(mk(1,0,0,1,1, 0,0,32'h00500000, 32'h00500000,1,32'h00400020,0));
      vecs.push_back(mk(1,0,0,1,0, 0,0,32'h00600000, 32'h00600000,2,32'h00500004,0));
      vecs.push_back(mk(0,0,0,1,1, 0,0,32'h00900000, 32'h00600000,2,32'h00500004,0));
      vecs.push_back(mk(1,1,1,1,0, 32'h00000100,32'h00800000,32'h00900000, 32'h00000100,0,0,0));
      vecs.push_back(mk(1,0,0,0,1, 0,0,0, 32'h00000104,0,0,1));
      vecs.push_back(mk(1,0,1,0,0, 0,32'hFFFFFFFC,0, 32'hFFFFFFFC,0,0,0));
      vecs.push_back(mk(1,0,0,0,0, 0,0,0, 32'h00000000,0,0,0));
      vecs.push_back(mk(1,0,1,1,0, 0,32'h00402000,32'h00A00000, 32'h00402000,0,0,0));

      rst = 1'b0;
      en = 0; trap_valid = 0; redirect_valid = 0; call = 0; ret = 0;
      trap_vec = 0; redirect_pc = 0; call_target = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset.pc",   pc, 32'h00400000);
      chk("reset.cnt",  32'(ras_count), 32'h0);
      chk("reset.top",  ras_top, 32'h0);
      chk("reset.miss", 32'(ras_miss), 32'h0);
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i]) begin
         apply(vecs[i]);
         chk($sformatf("vec%0d.pc", i),   pc, vecs[i].e_pc);
         chk($sformatf("vec%0d.cnt", i),  32'(ras_count), 32'(vecs[i].e_cnt));
         chk($sformatf("vec%0d.top", i),  ras_top, vecs[i].e_top);
         chk($sformatf("vec%0d.miss", i), 32'(ras_miss), 32'(vecs[i].e_miss));
      end

      // Asynchronous reset between edges while pc=0x00402000.
      #2 rst = 1'b0;
      #1;
      chk("async.pc",  pc, 32'h00400000);
      chk("async.cnt", 32'(ras_count), 32'h0);
      chk("async.top", ras_top, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();

      // RAS overflow: five calls from 0x00400000, T0, T1, T2, T3 (Tk = (k+1)<<16).
      for (int k = 0; k < 5; k++) begin
         v = mk(1,0,0,1,0, 0,0,32'((k+1) << 16), 0,0,0,0);
         apply(v);
      end
      chk("ovf.cnt", 32'(ras_count), 32'd4);
      chk("ovf.top", ras_top, 32'h00040004);
      chk("ovf.pc",  pc, 32'h00050000);
      for (int k = 3; k >= 0; k--) begin
         v = mk(1,0,0,0,1, 0,0,0, 0,0,0,0);
         apply(v);
         chk($sformatf("ovf.ret%0d", 3-k), pc, 32'(((k+1) << 16) + 4));
      end
      chk("ovf.empty", 32'(ras_count), 32'd0);
      v = mk(1,0,0,0,1, 0,0,0, 0,0,0,0);
      apply(v);
      chk("ovf.ret4.pc",   pc, 32'h00010008);
      chk("ovf.ret4.miss", 32'(ras_miss), 32'd1);
      chk_model("ovf.model");

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         v.en    = ($urandom % 4) != 0;
         v.trap  = ($urandom % 16) == 0;
         v.redir = ($urandom % 10) == 0;
         v.call  = ($urandom % 4) == 0;
         v.ret   = ($urandom % 3) == 0;
         v.tv    = $urandom;
         v.rp    = (($urandom % 8) == 0) ? 32'hFFFFFFF8 : $urandom;
         v.ct    = $urandom;
         apply(v);
         chk_model($sformatf("rnd%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
